// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: funct3 access encodings,
// byte-lane mask constants and the store lane-mask helper.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] LANE_NONE = 4'b0000;
   localparam logic [3:0] LANE_B    = 4'b0001;
   localparam logic [3:0] LANE_H    = 4'b0011;
   localparam logic [3:0] LANE_W    = 4'b1111;

   // Byte lanes touched by a store of the given size at the given offset.
   // Half stores look only at offset bit 1; word stores ignore the offset.
   function automatic logic [3:0] store_lane_mask(input logic [2:0] f3,
                                                  input logic [1:0] off);
      logic [3:0] m;
      m = LANE_NONE;
      case (f3)
         F3_B:    m = LANE_B << off;
         F3_H:    m = LANE_H << {off[1], 1'b0};
         F3_W:    m = LANE_W;
         default: m = LANE_NONE;
      endcase
      return m;
   endfunction

   // Store data replicated across lanes so every enabled lane sees its byte.
   function automatic logic [31:0] store_lane_data(input logic [2:0]  f3,
                                                   input logic [31:0] wd);
      logic [31:0] d;
      d = wd;
      case (f3)
         F3_B:    d = {4{wd[7:0]}};
         F3_H:    d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: selects the addressed byte/half of a memory word and
// sign- or zero-extends it per funct3. Illegal funct3 yields zero.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] read_data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Lane select (little-endian) followed by extension.
   always_comb begin
      sel_byte  = '0;
      sel_half  = offset[1] ? word[31:16] : word[15:0];
      read_data = '0;
      case (offset)
         2'd0:    sel_byte = word[7:0];
         2'd1:    sel_byte = word[15:8];
         2'd2:    sel_byte = word[23:16];
         default: sel_byte = word[31:24];
      endcase
      case (funct3)
         F3_B:    read_data = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   read_data = {24'd0, sel_byte};
         F3_H:    read_data = {{16{sel_half[15]}}, sel_half};
         F3_HU:   read_data = {16'd0, sel_half};
         F3_W:    read_data = word;
         default: read_data = '0;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// Word-organised RV32I data memory: combinational loads, byte-lane stores
// on the rising clock edge, out-of-range detection and a sticky fault flag.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses
// into faults; when undefined the low address bits are ignored per size.
module data_memory
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        access_fault,
   output logic        fault_sticky
);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] word_idx;
   logic [1:0]    byte_off;
   logic          out_of_range;
   logic          store_f3_bad;
   logic          misaligned;
   logic [3:0]    lane_mask;
   logic [31:0]   lane_data;
   logic [31:0]   aligned;

   assign word_idx = addr[AW+1:2];
   assign byte_off = addr[1:0];

   // Fault classification for the current access.
   always_comb begin
      out_of_range = (addr[31:AW+2] != '0);
      store_f3_bad = mem_write && !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
`ifdef DMEM_MISALIGN_TRAP_EN
      misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                   ((funct3 == F3_W) && (addr[1:0] != 2'b00));
`else
      misaligned = 1'b0;
`endif
      access_fault = (mem_read || mem_write) && (out_of_range || store_f3_bad || misaligned);
   end

   assign lane_mask = store_lane_mask(funct3, byte_off);
   assign lane_data = store_lane_data(funct3, write_data);

   // Byte-lane store; asynchronous reset clears every word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i[AW-1:0]] <= '0;
      end else if (mem_write && !access_fault) begin
         for (int unsigned lane = 0; lane < 4; lane++)
            if (lane_mask[lane[1:0]])
               mem[word_idx][lane*8 +: 8] <= lane_data[lane*8 +: 8];
      end
   end

   // Sticky fault flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fault_sticky <= 1'b0;
      else if (access_fault)
         fault_sticky <= 1'b1;
   end

   dmem_load_align u_align (
      .word      (mem[word_idx]),
      .offset    (byte_off),
      .funct3    (funct3),
      .read_data (aligned)
   );

   // Load result gated off when idle, faulting or held in reset.
   always_comb begin
      read_data = '0;
      if (mem_read && !access_fault && !rst)
         read_data = aligned;
   end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (DEPTH=256).
module tb_data_memory;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        access_fault;
   logic        fault_sticky;

   int tests_run;
   int tests_failed;

   data_memory #(.DEPTH(256), .AW(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .funct3       (funct3),
      .addr         (addr),
      .write_data   (write_data),
      .read_data    (read_data),
      .access_fault (access_fault),
      .fault_sticky (fault_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      mem_read   = 1'b0;
      mem_write  = 1'b1;
      funct3     = f3;
      addr       = a;
      write_data = d;
      @(posedge clk);
      #1;
      mem_write  = 1'b0;
   endtask

   task automatic load_chk(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] exp);
      @(negedge clk);
      mem_write = 1'b0;
      mem_read  = 1'b1;
      funct3    = f3;
      addr      = a;
      #1;
      check(tag, read_data, exp);
      mem_read  = 1'b0;
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      funct3 = 3'b010; addr = '0; write_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_sticky", {31'd0, fault_sticky}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Store, then reset mid-run; data must be gone afterwards.
      store(3'b010, 32'h10, 32'hDEADBEEF);
      load_chk("pre_reset_lw", 3'b010, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      mem_write = 1'b1; funct3 = 3'b010; addr = 32'h20; write_data = 32'h77777777;
      #2 rst = 1'b1;
      #1;
      mem_write = 1'b0; mem_read = 1'b1; addr = 32'h10;
      #1;
      check("rd_during_rst", read_data, 32'd0);
      @(negedge clk);
      rst = 1'b0; mem_read = 1'b0;
      load_chk("rst_lw_0", 3'b010, 32'h0, 32'd0);
      load_chk("rst_lw_3fc", 3'b010, 32'h3FC, 32'd0);
      load_chk("rst_lw_10", 3'b010, 32'h10, 32'd0);
      load_chk("rst_lost_store", 3'b010, 32'h20, 32'd0);
      check("rst_sticky", {31'd0, fault_sticky}, 32'd0);

      // Word store then the byte/half load variants.
      store(3'b010, 32'h10, 32'hDEADBEEF);
      load_chk("lw_10", 3'b010, 32'h10, 32'hDEADBEEF);
      load_chk("lb_10", 3'b000, 32'h10, 32'hFFFFFFEF);
      load_chk("lbu_13", 3'b100, 32'h13, 32'h000000DE);
      load_chk("lb_13", 3'b000, 32'h13, 32'hFFFFFFDE);
      load_chk("lbu_10", 3'b100, 32'h10, 32'h000000EF);
      load_chk("lh_12", 3'b001, 32'h12, 32'hFFFFDEAD);
      load_chk("lhu_10", 3'b101, 32'h10, 32'h0000BEEF);
      load_chk("lh_10", 3'b001, 32'h10, 32'hFFFFBEEF);
      load_chk("illegal_f3_ld", 3'b011, 32'h10, 32'd0);

      // Partial stores.
      store(3'b000, 32'h11, 32'hAAAAAA55);
      load_chk("sb_lw", 3'b010, 32'h10, 32'hDEAD55EF);
      store(3'b001, 32'h12, 32'hBBBB1234);
      load_chk("sh_lw", 3'b010, 32'h10, 32'h123455EF);

      // Read-during-write returns old data; new data one cycle later.
      store(3'b010, 32'h20, 32'h11111111);
      @(negedge clk);
      mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b010;
      addr = 32'h20; write_data = 32'hCAFEF00D;
      #1;
      check("rdw_old", read_data, 32'h11111111);
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      #1;
      check("rdw_new", read_data, 32'hCAFEF00D);
      mem_read = 1'b0;

      // Last in-range word.
      store(3'b010, 32'h3FC, 32'hA5A5A5A5);
      load_chk("lw_3fc", 3'b010, 32'h3FC, 32'hA5A5A5A5);
      check("sticky_clean", {31'd0, fault_sticky}, 32'd0);

      // Out-of-range store must fault and not alias onto word 0.
      @(negedge clk);
      mem_write = 1'b1; funct3 = 3'b010; addr = 32'h400; write_data = 32'hFFFFFFFF;
      #1;
      check("oor_fault", {31'd0, access_fault}, 32'd1);
      check("oor_sticky_pre", {31'd0, fault_sticky}, 32'd0);
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      check("oor_sticky", {31'd0, fault_sticky}, 32'd1);
      load_chk("oor_no_alias", 3'b010, 32'h0, 32'd0);
      load_chk("oor_lw", 3'b010, 32'h400, 32'd0);
      @(negedge clk);
      mem_read = 1'b1; addr = 32'h400;
      #1;
      check("oor_ld_fault", {31'd0, access_fault}, 32'd1);
      mem_read = 1'b0;
      #1;
      check("idle_no_fault", {31'd0, access_fault}, 32'd0);
      check("idle_rd_zero", read_data, 32'd0);

      // Store with a load-only funct3 is a fault and writes nothing.
      @(negedge clk);
      mem_write = 1'b1; funct3 = 3'b100; addr = 32'h10; write_data = 32'h0;
      #1;
      check("bad_f3_st_fault", {31'd0, access_fault}, 32'd1);
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      load_chk("bad_f3_st_mem", 3'b010, 32'h10, 32'h123455EF);

      // Misaligned word access.
      @(negedge clk);
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h11;
      #1;
`ifdef DMEM_MISALIGN_TRAP_EN
      check("mis_lw_fault", {31'd0, access_fault}, 32'd1);
      check("mis_lw_data", read_data, 32'd0);
`else
      check("mis_lw_fault", {31'd0, access_fault}, 32'd0);
      check("mis_lw_data", read_data, 32'h123455EF);
`endif
      mem_read = 1'b0;
      store(3'b010, 32'h13, 32'h0BADF00D);
`ifdef DMEM_MISALIGN_TRAP_EN
      load_chk("mis_sw_mem", 3'b010, 32'h10, 32'h123455EF);
`else
      load_chk("mis_sw_mem", 3'b010, 32'h10, 32'h0BADF00D);
`endif

      // Final reset clears the sticky flag and memory.
      @(negedge clk);
      rst = 1'b1;
      #2;
      check("final_rst_sticky", {31'd0, fault_sticky}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      load_chk("final_rst_mem", 3'b010, 32'h3FC, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data memory for the single-cycle RV32I core; sits between the ALU (address/store data) and the write-back select mux, whose memory input is `read_data`.
- Supports byte, half and word loads and stores per funct3, with sign/zero extension of loads.
- Synchronous byte-lane writes, combinational reads.
- Detects out-of-range accesses; misaligned handling is selected by a macro.

Parameters:
- DEPTH, 256, number of 32-bit words (power of two).
- AW, 8, word-index width, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  asynchronous, active-high reset
- mem_read  input  1  load enable
- mem_write  input  1  store enable
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  byte address from ALU
- write_data  input  32  store data (rs2)
- read_data  output  32  extended load result to write-back mux
- access_fault  output  1  current access illegal (combinational)
- fault_sticky  output  1  registered; set on any faulting access, cleared only by rst

Behaviour:
- Word index is addr[AW+1:2]. Byte offset is addr[1:0].
- Out of range: addr[31:AW+2] != 0 with mem_read or mem_write -> access_fault=1.
- Reset:
  - rst high asynchronously clears all DEPTH words and fault_sticky to 0.
  - While rst is high, writes are ignored and read_data=0.
  - Reset mid-store: the store is lost and memory reads 0 after reset.
- Loads (combinational, zero-cycle latency):
  - mem_read=1 and no fault:
    - B/BU: select byte addr[1:0] (little-endian), sign- or zero-extend.
    - H/HU: select half addr[1]; sign- or zero-extend.
    - W: full word.
  - mem_read=0, a fault, or an illegal funct3 (011, 110, 111) -> read_data=0.
- Stores (one-cycle latency):
  - Byte lanes are written at the rising clk edge when mem_write=1 and there is no fault.
  - SB writes lane addr[1:0] with write_data[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with write_data[15:0].
  - SW writes all four lanes.
  - funct3 values other than 000/001/010 -> no write, access_fault=1.
- Simultaneous mem_read and mem_write to the same address: read_data returns the old contents. The new value is visible the cycle after the edge.
- mem_read and mem_write both 0 -> access_fault=0, no state change.
- fault_sticky is set on the clk edge where access_fault=1. Sticky until rst.
- Index wraps naturally only within DEPTH. Anything beyond DEPTH is a fault, never aliased.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Half access with addr[0]=1, or word access with addr[1:0]!=0, raises access_fault.
  - The store is suppressed and read_data=0.
- Undefined:
  - Low address bits are ignored for the access size (H uses addr[1] only, W uses the word index).
  - Misalignment never faults.

Decomposition:
- Package dmem_pkg holds:
  - funct3 encodings F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - lane-mask constants.
- Sub-module dmem_load_align: purely combinational lane select plus sign/zero extension (word, offset, funct3 -> read_data). It is reused by a future load/store unit.

Test Plan:
- Reset: assert rst mid-run, then release; LW of addr 0x0 and 0x3FC -> read_data=0, fault_sticky=0.
- Word store/load: SW 0xDEADBEEF @0x10, next cycle LW @0x10 -> 0xDEADBEEF.
- Byte loads after that store:
  - LB @0x10 -> 0xFFFFFFEF
  - LBU @0x13 -> 0x000000DE
  - LH @0x12 -> 0xFFFFDEAD
  - LHU @0x10 -> 0x0000BEEF
- Partial store: SB 0x55 @0x11 -> LW @0x10 = 0xDEAD55EF. SH 0x1234 @0x12 -> LW @0x10 = 0x123455EF.
- Fault: SW @0x400 (DEPTH=256) -> access_fault=1 that cycle, fault_sticky=1 next edge, memory unchanged; LW @0x400 -> read_data=0.
- Misalign, with DMEM_MISALIGN_TRAP_EN: LW @0x11 -> access_fault=1, read_data=0. Without the macro: LW @0x11 -> 0x123455EF, no fault.
